// File: rtl/issue_ctrl_pkg.sv
// Shared operation codes, widths and classification helpers
// for the issue stage and its decoder.
package issue_ctrl_pkg;

    localparam int INS_W      = 32;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int OPE_W      = 6;
    localparam int REG_NUMBER = 32;
    localparam int REG_W      = $clog2(REG_NUMBER);

    typedef enum logic [OPE_W-1:0] {
        EMPTY_INS = 6'd0,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI,
        SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } op_e;

    function automatic logic is_mem(input op_e op);
        return op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    endfunction

    function automatic logic writes_rd(input op_e op);
        return !(op inside {EMPTY_INS, BEQ, BNE, BLT, BGE, BLTU, BGEU,
                            SB, SH, SW});
    endfunction

endpackage

// File: rtl/issue_ctrl_decoder.sv
// RV32I base decoder: op type, register indices and immediate.
// Unknown encodings decode to EMPTY_INS.
import issue_ctrl_pkg::*;

module issue_ctrl_decoder (
    input  logic [INS_W-1:0]  ins,
    output op_e               op,
    output logic [REG_W-1:0]  rd,
    output logic [REG_W-1:0]  rs1,
    output logic [REG_W-1:0]  rs2,
    output logic [DATA_W-1:0] imm
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_b;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] imm_j;
    logic [DATA_W-1:0] imm_sh;

    assign opc    = ins[6:0];
    assign f3     = ins[14:12];
    assign f7     = ins[31:25];
    assign imm_i  = {{20{ins[31]}}, ins[31:20]};
    assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25],
                     ins[11:8], 1'b0};
    assign imm_u  = {ins[31:12], 12'b0};
    assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20],
                     ins[30:21], 1'b0};
    assign imm_sh = {27'b0, ins[24:20]};

    always_comb begin
        op  = EMPTY_INS;
        rd  = '0;
        rs1 = '0;
        rs2 = '0;
        imm = '0;
        unique case (opc)
            7'b0110111: begin
                op = LUI; rd = ins[11:7]; imm = imm_u;
            end
            7'b0010111: begin
                op = AUIPC; rd = ins[11:7]; imm = imm_u;
            end
            7'b1101111: begin
                op = JAL; rd = ins[11:7]; imm = imm_j;
            end
            7'b1100111: begin
                if (f3 == 3'd0) op = JALR;
                rd = ins[11:7]; rs1 = ins[19:15]; imm = imm_i;
            end
            7'b1100011: begin
                rs1 = ins[19:15]; rs2 = ins[24:20]; imm = imm_b;
                case (f3)
                    3'd0:    op = BEQ;
                    3'd1:    op = BNE;
                    3'd4:    op = BLT;
                    3'd5:    op = BGE;
                    3'd6:    op = BLTU;
                    3'd7:    op = BGEU;
                    default: op = EMPTY_INS;
                endcase
            end
            7'b0000011: begin
                rd = ins[11:7]; rs1 = ins[19:15]; imm = imm_i;
                case (f3)
                    3'd0:    op = LB;
                    3'd1:    op = LH;
                    3'd2:    op = LW;
                    3'd4:    op = LBU;
                    3'd5:    op = LHU;
                    default: op = EMPTY_INS;
                endcase
            end
            7'b0100011: begin
                rs1 = ins[19:15]; rs2 = ins[24:20]; imm = imm_s;
                case (f3)
                    3'd0:    op = SB;
                    3'd1:    op = SH;
                    3'd2:    op = SW;
                    default: op = EMPTY_INS;
                endcase
            end
            7'b0010011: begin
                rd = ins[11:7]; rs1 = ins[19:15]; imm = imm_i;
                case (f3)
                    3'd0: op = ADDI;
                    3'd2: op = SLTI;
                    3'd3: op = SLTIU;
                    3'd4: op = XORI;
                    3'd6: op = ORI;
                    3'd7: op = ANDI;
                    3'd1: begin
                        imm = imm_sh;
                        if (f7 == 7'h00) op = SLLI;
                    end
                    default: begin
                        imm = imm_sh;
                        if (f7 == 7'h00) op = SRLI;
                        else if (f7 == 7'h20) op = SRAI;
                    end
                endcase
            end
            7'b0110011: begin
                rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20];
                case ({f7, f3})
                    {7'h00, 3'd0}: op = ADD;
                    {7'h20, 3'd0}: op = SUB;
                    {7'h00, 3'd1}: op = SLL;
                    {7'h00, 3'd2}: op = SLT;
                    {7'h00, 3'd3}: op = SLTU;
                    {7'h00, 3'd4}: op = XOR;
                    {7'h00, 3'd5}: op = SRL;
                    {7'h20, 3'd5}: op = SRA;
                    {7'h00, 3'd6}: op = OR;
                    {7'h00, 3'd7}: op = AND;
                    default:       op = EMPTY_INS;
                endcase
            end
            default: op = EMPTY_INS;
        endcase
    end

endmodule

// File: rtl/issue_ctrl.sv
// Issue stage: pops the IQ head, decodes it into a single issue
// register and dispatches to ROB plus RS or LSB.
import issue_ctrl_pkg::*;

module issue_ctrl #(
    parameter int ROB_IDX_W = 4,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 rdy_in,
    input  logic                 flush_in,
    input  logic                 iq_valid,
    input  logic [INS_W-1:0]     iq_ins,
    input  logic [ADDR_W-1:0]    iq_pc,
    input  logic                 iq_pred_taken,
    output logic                 iq_pop,
    input  logic                 rob_full,
    input  logic [ROB_IDX_W-1:0] rob_tail,
    input  logic                 rs_full,
    input  logic                 lsb_full,
    output logic                 rob_alloc,
    output logic                 rs_alloc,
    output logic                 lsb_alloc,
    output logic [OPE_W-1:0]     dis_type,
    output logic [REG_W-1:0]     dis_rd,
    output logic [REG_W-1:0]     dis_rs1,
    output logic [REG_W-1:0]     dis_rs2,
    output logic                 dis_rd_valid,
    output logic [DATA_W-1:0]    dis_imm,
    output logic [ADDR_W-1:0]    dis_pc,
    output logic                 dis_pred_taken,
    output logic [ROB_IDX_W-1:0] dis_tag,
    output logic                 illegal_out,
    output logic [CNT_W-1:0]     issued_cnt
);

    typedef enum logic {S_EMPTY, S_HELD} state_e;

    state_e            state_q, state_d;
    op_e               type_q, type_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic [REG_W-1:0]  rs1_q, rs1_d;
    logic [REG_W-1:0]  rs2_q, rs2_d;
    logic              rdv_q, rdv_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pred_q, pred_d;
    logic              ill_q, ill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    op_e               dec_op;
    logic [REG_W-1:0]  dec_rd;
    logic [REG_W-1:0]  dec_rs1;
    logic [REG_W-1:0]  dec_rs2;
    logic [DATA_W-1:0] dec_imm;

    logic held, go, mem_q, tgt_ok, fire, pop, dec_ok;

    issue_ctrl_decoder u_dec (
        .ins (iq_ins),
        .op  (dec_op),
        .rd  (dec_rd),
        .rs1 (dec_rs1),
        .rs2 (dec_rs2),
        .imm (dec_imm)
    );

    // go folds in reset so the combinational strobes stay low during it
    assign held   = (state_q == S_HELD);
    assign go     = rst_n_in & rdy_in & ~flush_in;
    assign mem_q  = is_mem(type_q);
    assign tgt_ok = ~rob_full & (mem_q ? ~lsb_full : ~rs_full);
    assign fire   = go & held & tgt_ok;
    assign pop    = go & iq_valid & (~held | tgt_ok);
    assign dec_ok = (dec_op != EMPTY_INS);

    assign iq_pop         = pop;
    assign rob_alloc      = fire;
    assign rs_alloc       = fire & ~mem_q;
    assign lsb_alloc      = fire & mem_q;
    assign dis_tag        = fire ? rob_tail : '0;
    assign dis_type       = type_q;
    assign dis_rd         = rd_q;
    assign dis_rs1        = rs1_q;
    assign dis_rs2        = rs2_q;
    assign dis_rd_valid   = rdv_q;
    assign dis_imm        = imm_q;
    assign dis_pc         = pc_q;
    assign dis_pred_taken = pred_q;
    assign illegal_out    = ill_q;
    assign issued_cnt     = cnt_q;

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rdv_d   = rdv_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        pred_d  = pred_q;
        cnt_d   = cnt_q + CNT_W'(fire);
        ill_d   = pop & ~dec_ok;
        if (flush_in) begin
            state_d = S_EMPTY;
        end else if (pop && dec_ok) begin
            state_d = S_HELD;
            type_d  = dec_op;
            rd_d    = dec_rd;
            rs1_d   = dec_rs1;
            rs2_d   = dec_rs2;
            rdv_d   = writes_rd(dec_op) & (dec_rd != '0);
            imm_d   = dec_imm;
            pc_d    = iq_pc;
            pred_d  = iq_pred_taken;
        end else if (fire) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_EMPTY;
            type_q  <= EMPTY_INS;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rdv_q   <= 1'b0;
            imm_q   <= '0;
            pc_q    <= '0;
            pred_q  <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            type_q  <= type_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rdv_q   <= rdv_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            pred_q  <= pred_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
